data_ram_ctrl: RTL
==================

Name: data_ram_ctrl

Overview:
- Parametrised successor to the processor's single-port word RAM: data memory with a request/response handshake, byte/halfword/word access and sign-extended loads.
- Adds a configurable read-pipeline latency and misalignment detection.
- Sits between the CPU load/store stage and the memory array.
- Word-organised storage, 32-bit data, byte-addressed requests.

Parameters:
- ADDR_WIDTH, 14, word-address width; depth = 2**ADDR_WIDTH words of 32 bits.
- READ_LATENCY, 1, cycles from request acceptance to response. Legal values 1..3; other values are a synthesis error.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_WIDTH+2  byte address.
- req_size  input  2  access size: 00 = byte, 01 = halfword, 10 = word; 11 is reserved and treated as misaligned.
- req_signed  input  1  sign-extend a load (byte/halfword only).
- req_wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- rsp_valid  output  1  response strobe, one cycle per accepted request.
- rsp_rdata  output  32  load result, right-aligned and extended.
- rsp_error  output  1  accepted request was misaligned or reserved.

Behaviour:
- Reset (reset_n low, asynchronous):
  - rsp_valid = 0, rsp_rdata = 0, rsp_error = 0.
  - Response pipeline flushed; in-flight responses are discarded and never emitted.
  - req_ready per the Optional Feature.
- Acceptance:
  - A request is accepted on a posedge where req_valid && req_ready.
  - At most one request per cycle; there is no backpressure on the response side.
- Alignment:
  - halfword requires addr[0] = 0; word requires addr[1:0] = 00; byte is always aligned.
  - Misaligned or size 11: no memory write; response carries rsp_error = 1 and rsp_rdata = 0.
- Store, aligned:
  - The word at addr[ADDR_WIDTH+1:2] is updated on the accepting edge.
  - Only the addressed byte lanes change: byte lane = addr[1:0]; halfword lanes = addr[1]*2 and addr[1]*2+1.
  - Response: rsp_rdata = 0, rsp_error = 0.
- Load, aligned:
  - The word is read at acceptance, then the lane is selected and shifted to bit 0.
  - Zero-extended when req_signed = 0, sign-extended when req_signed = 1. req_signed is ignored for word loads.
- Latency:
  - The response for a request accepted at edge N appears with rsp_valid = 1 after edge N+READ_LATENCY, for exactly one cycle.
  - Back-to-back requests give back-to-back responses, in order.
  - rsp_rdata and rsp_error hold their last value when rsp_valid = 0.
- Read-after-write:
  - A load accepted one or more cycles after a store to the same word returns the new data. This holds for every READ_LATENCY.
  - There is no same-cycle hazard, since only one request is accepted per cycle.
- Address width: the upper address bits select the word directly; there is no wrap or out-of-range condition.
- States:
  - RUN: req_ready = 1.
  - INIT: exists only with the Optional Feature.

Optional Feature:
- Macro: DATA_RAM_CLEAR_ON_RESET_EN.
- Defined:
  - On reset release the FSM enters INIT; req_ready = 0 in INIT.
  - A clear counter writes 0 to words 0 .. 2**ADDR_WIDTH-1, one word per cycle.
  - After the last word is written, the FSM moves to RUN and req_ready = 1, exactly 2**ADDR_WIDTH cycles after the first post-reset edge.
  - Reset asserted during INIT restarts the sweep from word 0.
- Undefined:
  - There is no INIT state; req_ready = 1 from the first edge after reset release.
  - Memory contents are not cleared and persist across reset.

Test Plan:
1. Store word 0x80FF7F01 at addr 0x0010, then load word, unsigned, from 0x0010. Required: rsp_valid exactly READ_LATENCY cycles after each acceptance; load returns 0x80FF7F01 with rsp_error = 0.
2. Then issue byte loads from 0x0010..0x0013 with req_signed = 1. Required: 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80. With req_signed = 0 the byte at 0x0013 returns 0x00000080.
3. Store halfword 0xBEEF at 0x0012, then load word from 0x0010. Required: 0xBEEF7F01, so the low lanes are untouched. Then a signed halfword load from 0x0012 returns 0xFFFFBEEF.
4. Store word at 0x0011, load halfword from 0x0013, and issue a request with req_size = 11. Required: each response has rsp_error = 1 and rsp_rdata = 0. A following word load from 0x0010 still returns 0xBEEF7F01.
5. Issue 4 back-to-back loads with READ_LATENCY = 3, then assert reset_n low 2 cycles after the last acceptance. Required: rsp_valid = 0 immediately and the remaining responses are never emitted. Responses before reset arrive in order on consecutive cycles.
6. With DATA_RAM_CLEAR_ON_RESET_EN and ADDR_WIDTH = 4, release reset after prior stores. Required: req_ready = 0 for 16 cycles, then 1, and every word reads 0x00000000. Reset asserted mid-sweep at cycle 7 restarts the full 16-cycle sweep.

Source files
------------

// File: rtl/data_ram_ctrl_if.sv
// rtl/data_ram_ctrl_if.sv - request/response bus between the load/store stage and data_ram_ctrl
//
// Purpose: groups the data memory request/response handshake.
// Ports (signals):
//   req_valid/req_ready  request handshake, accepted when both are high on a clock edge
//   req_we               1 = store, 0 = load
//   req_addr             byte address, ADDR_WIDTH+2 bits
//   req_size             00 byte, 01 halfword, 10 word, 11 reserved
//   req_signed           sign-extend byte/halfword loads
//   req_wdata            right-aligned store data
//   rsp_valid            one-cycle response strobe per accepted request
//   rsp_rdata            right-aligned, extended load data
//   rsp_error            request was misaligned or reserved
// Modports: master = load/store stage, slave = data_ram_ctrl.
interface data_ram_ctrl_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_error;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/data_ram_ctrl.sv
// rtl/data_ram_ctrl.sv - word-organised data RAM with byte/half/word access and pipelined responses
//
// Purpose: 2**ADDR_WIDTH x 32-bit data memory with byte-lane stores, extended
// loads, misalignment detection and a READ_LATENCY-cycle (1..3) response pipe.
// Ports:
//   clock    system clock, all state on posedge
//   reset_n  asynchronous active-low reset, flushes the response pipe
//   bus      data_ram_ctrl_if.slave request/response bus
// Optional feature macro: DATA_RAM_CLEAR_ON_RESET_EN - after reset an INIT
// sweep writes zero to every word, one per cycle, with req_ready low.
module data_ram_ctrl #(
  parameter int ADDR_WIDTH   = 14,
  parameter int READ_LATENCY = 1
) (
  input logic           clock,
  input logic           reset_n,
  data_ram_ctrl_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
    $error("data_ram_ctrl: READ_LATENCY must be in 1..3");
  end

  typedef struct packed {
    logic        v;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic [31:0]           mem [DEPTH];
  logic                  ready;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

`ifdef DATA_RAM_CLEAR_ON_RESET_EN
  typedef enum logic {INIT, RUN} state_t;
  state_t state;

  // Reset during INIT lands back here with the counter at zero, restarting the sweep.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= INIT;
      clr_addr <= '0;
      ready    <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          clr_addr <= clr_addr + 1'b1;
          if (&clr_addr) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        default: ready <= 1'b1;
      endcase
    end
  end

  assign clr_we = (state == INIT);
`else
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ready <= 1'b0;
    else          ready <= 1'b1;
  end

  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  assign bus.req_ready = ready;

  // Request decode
  logic                  accept;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [1:0]            lane;
  logic                  misaligned;
  logic [3:0]            be;
  logic [31:0]           wlanes;
  logic                  st_en;

  assign accept    = bus.req_valid && ready;
  assign word_addr = bus.req_addr[ADDR_WIDTH+1:2];
  assign lane      = bus.req_addr[1:0];
  assign st_en     = accept && bus.req_we && !misaligned;

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    misaligned = 1'b0;
    be         = 4'b0000;
    wlanes     = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        be     = 4'b0001 << lane;
        wlanes = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = lane[0];
        be         = lane[1] ? 4'b1100 : 4'b0011;
        wlanes     = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        misaligned = |lane;
        be         = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Storage: no reset so contents persist across reset when the sweep is absent.
  logic [31:0] rd_word;

  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (st_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_addr][8*b +: 8] <= wlanes[8*b +: 8];
      end
    end
    if (accept) rd_word <= mem[word_addr];
  end

  // Stage 1: request attributes aligned with rd_word
  logic       s1_v;
  logic       s1_err;
  logic       s1_load;
  logic [1:0] s1_size;
  logic [1:0] s1_lane;
  logic       s1_signed;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_v      <= 1'b0;
      s1_err    <= 1'b0;
      s1_load   <= 1'b0;
      s1_size   <= 2'b00;
      s1_lane   <= 2'b00;
      s1_signed <= 1'b0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_err    <= misaligned;
        s1_load   <= !bus.req_we;
        s1_size   <= bus.req_size;
        s1_lane   <= lane;
        s1_signed <= bus.req_signed;
      end
    end
  end

  // Lane select, shift to bit 0, extend. Stores and errors report zero data.
  rsp_t        fmt;
  logic [31:0] shifted;

  always_comb begin
    shifted  = rd_word >> {s1_lane, 3'b000};
    fmt      = '0;
    fmt.v    = s1_v;
    fmt.err  = s1_err;
    if (s1_load && !s1_err) begin
      case (s1_size)
        2'b00:   fmt.data = {{24{s1_signed & shifted[7]}}, shifted[7:0]};
        2'b01:   fmt.data = {{16{s1_signed & shifted[15]}}, shifted[15:0]};
        default: fmt.data = rd_word;
      endcase
    end
  end

  // Extra delay stages so the output register lands READ_LATENCY edges after acceptance.
  rsp_t tail;

  if (READ_LATENCY == 1) begin : g_lat1
    assign tail = fmt;
  end else begin : g_latn
    rsp_t dly [READ_LATENCY-1];

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < READ_LATENCY - 1; i++) dly[i] <= '0;
      end else begin
        dly[0] <= fmt;
        for (int i = 1; i < READ_LATENCY - 1; i++) dly[i] <= dly[i-1];
      end
    end

    assign tail = dly[READ_LATENCY-2];
  end

  // Data/error hold their last value between strobes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_error <= 1'b0;
    end else begin
      bus.rsp_valid <= tail.v;
      if (tail.v) begin
        bus.rsp_rdata <= tail.data;
        bus.rsp_error <= tail.err;
      end
    end
  end
endmodule
